// File: rtl/iob_regfile_fifo_ctrl_pkg.sv
// Shared sizing helpers and types for the register-file FIFO controller.
package iob_regfile_fifo_ctrl_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 21;

    // Net effect of one cycle on the stored-entry count.
    typedef enum logic [1:0] {
        LVL_HOLD = 2'd0,
        LVL_INC  = 2'd1,
        LVL_DEC  = 2'd2
    } lvl_op_e;

    function automatic int depth_f(input int addr_w);
        return 32'sd1 << addr_w;
    endfunction

    // One extra bit so the count can represent a completely full store.
    function automatic int lvl_w_f(input int addr_w);
        return addr_w + 32'sd1;
    endfunction

    function automatic int ptr_inc_f(input int ptr, input int addr_w);
        if (ptr == depth_f(addr_w) - 32'sd1) begin
            return 32'sd0;
        end else begin
            return ptr + 32'sd1;
        end
    endfunction

endpackage

// File: rtl/iob_fifo_out_reg.sv
// Valid/ready output register: captures regfile read data on a load and
// drops valid once the consumer takes the last word with nothing behind it.
module iob_fifo_out_reg #(
    parameter int DATA_W = 21
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              ld_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Output stage state: load wins over drain; data holds after drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (ld_i) begin
            r_valid <= 1'b1;
            r_data  <= data_i;
        end else if (cke_i && r_valid && ready_i) begin
            r_valid <= 1'b0;
            r_data  <= r_data;
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;

endmodule

// File: rtl/iob_regfile_fifo_ctrl.sv
// FIFO controller driving an external 2-port regfile plus one output register.
// Optional almost-full/almost-empty flags: define IOB_REGFILE_FIFO_CTRL_ALMOST_EN.
module iob_regfile_fifo_ctrl
    import iob_regfile_fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef IOB_REGFILE_FIFO_CTRL_ALMOST_EN
    ,
    parameter int ALMOST_FULL_LVL  = (32'sd1 << ADDR_W) - 32'sd1,
    parameter int ALMOST_EMPTY_LVL = 32'sd1
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cke_i,
    input  logic              w_en_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic              w_full_o,
    output logic              w_overflow_o,
    output logic              r_valid_o,
    input  logic              r_ready_i,
    output logic [DATA_W-1:0] r_data_o,
    output logic [ADDR_W:0]   level_o,
`ifdef IOB_REGFILE_FIFO_CTRL_ALMOST_EN
    output logic              almost_full_o,
    output logic              almost_empty_o,
`endif
    output logic              ext_w_en_o,
    output logic [ADDR_W-1:0] ext_w_addr_o,
    output logic [DATA_W-1:0] ext_w_data_o,
    output logic [ADDR_W-1:0] ext_r_addr_o,
    input  logic [DATA_W-1:0] ext_r_data_i
);

    localparam int                DEPTH    = depth_f(ADDR_W);
    localparam int                LVL_W    = lvl_w_f(ADDR_W);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [LVL_W-1:0]  r_level;
    logic              r_overflow;

    logic              w_full;
    logic              w_wr;
    logic              w_ld;
    logic              w_out_valid;
    lvl_op_e           w_lvl_op;

    // Full is judged on the registered level, so a same-cycle load never
    // opens room for a write.
    assign w_full = (r_level == FULL_LVL);
    assign w_wr   = cke_i & w_en_i & ~w_full;
    assign w_ld   = cke_i & (r_level != {LVL_W{1'b0}}) & (~w_out_valid | r_ready_i);

    // Decode the net change in stored entries for this cycle.
    always_comb begin
        w_lvl_op = LVL_HOLD;
        if (w_wr && !w_ld) begin
            w_lvl_op = LVL_INC;
        end else if (w_ld && !w_wr) begin
            w_lvl_op = LVL_DEC;
        end else begin
            w_lvl_op = LVL_HOLD;
        end
    end

    // Pointers, level and overflow flag; everything holds while cke_i is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else if (cke_i) begin
            if (w_wr) begin
                r_wptr <= ADDR_W'(ptr_inc_f(int'(r_wptr), ADDR_W));
            end else begin
                r_wptr <= r_wptr;
            end
            if (w_ld) begin
                r_rptr <= ADDR_W'(ptr_inc_f(int'(r_rptr), ADDR_W));
            end else begin
                r_rptr <= r_rptr;
            end
            case (w_lvl_op)
                LVL_INC: r_level <= r_level + LVL_ONE;
                LVL_DEC: r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            r_overflow <= w_en_i & w_full;
        end else begin
            r_wptr     <= r_wptr;
            r_rptr     <= r_rptr;
            r_level    <= r_level;
            r_overflow <= r_overflow;
        end
    end

    iob_fifo_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cke_i   (cke_i),
        .ld_i    (w_ld),
        .ready_i (r_ready_i),
        .data_i  (ext_r_data_i),
        .valid_o (w_out_valid),
        .data_o  (r_data_o)
    );

    assign r_valid_o    = w_out_valid;
    assign w_full_o     = w_full;
    assign w_overflow_o = r_overflow;
    assign level_o      = r_level;
    assign ext_w_en_o   = w_wr;
    assign ext_w_addr_o = r_wptr;
    assign ext_w_data_o = w_data_i;
    assign ext_r_addr_o = r_rptr;

`ifdef IOB_REGFILE_FIFO_CTRL_ALMOST_EN
    assign almost_full_o  = (r_level >= LVL_W'(ALMOST_FULL_LVL));
    assign almost_empty_o = (r_level <= LVL_W'(ALMOST_EMPTY_LVL));
`endif

endmodule

// File: tb/tb_iob_regfile_fifo_ctrl.sv
// Directed bench for iob_regfile_fifo_ctrl with a behavioural 8x21 regfile.
module tb_iob_regfile_fifo_ctrl;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 21;

    logic              clk;
    logic              rst;
    logic              cke;
    logic              w_en;
    logic [DATA_W-1:0] w_data;
    logic              w_full;
    logic              w_overflow;
    logic              r_valid;
    logic              r_ready;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W:0]   level;
    logic              ext_w_en;
    logic [ADDR_W-1:0] ext_w_addr;
    logic [DATA_W-1:0] ext_w_data;
    logic [ADDR_W-1:0] ext_r_addr;
    logic [DATA_W-1:0] ext_r_data;
`ifdef IOB_REGFILE_FIFO_CTRL_ALMOST_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    logic [DATA_W-1:0] mem [8];

    int nvec = 0;
    int nerr = 0;

    iob_regfile_fifo_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cke_i        (cke),
        .w_en_i       (w_en),
        .w_data_i     (w_data),
        .w_full_o     (w_full),
        .w_overflow_o (w_overflow),
        .r_valid_o    (r_valid),
        .r_ready_i    (r_ready),
        .r_data_o     (r_data),
        .level_o      (level),
`ifdef IOB_REGFILE_FIFO_CTRL_ALMOST_EN
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
`endif
        .ext_w_en_o   (ext_w_en),
        .ext_w_addr_o (ext_w_addr),
        .ext_w_data_o (ext_w_data),
        .ext_r_addr_o (ext_r_addr),
        .ext_r_data_i (ext_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ext_w_en) mem[ext_w_addr] <= ext_w_data;
    end
    assign ext_r_data = mem[ext_r_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_drain [8];

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        exp_drain = '{32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hB};
        rst = 1'b1; cke = 1'b1; w_en = 1'b0; w_data = '0; r_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_valid", 32'(r_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_full", 32'(w_full), 32'd0);
        chk("rst_wen", 32'(ext_w_en), 32'd0);
        chk("rst_data", 32'(r_data), 32'd0);
        chk("rst_ovf", 32'(w_overflow), 32'd0);

        // Fill with consumer stalled: 9 writes fit (8 in regfile + 1 in output).
        for (int k = 1; k <= 9; k++) begin
            w_en = 1'b1; w_data = DATA_W'(k);
            #1;
            chk("fill_wen", 32'(ext_w_en), 32'd1);
            chk("fill_waddr", 32'(ext_w_addr), 32'((k - 1) % 8));
            tick();
            if (k == 8) begin
                chk("fill8_level", 32'(level), 32'd7);
                chk("fill8_data", 32'(r_data), 32'h1);
                chk("fill8_valid", 32'(r_valid), 32'd1);
            end
        end
        chk("fill9_level", 32'(level), 32'd8);
        chk("fill9_full", 32'(w_full), 32'd1);
        w_data = 21'hA;
        #1;
        chk("ovf_wen", 32'(ext_w_en), 32'd0);
        tick();
        chk("ovf_pulse", 32'(w_overflow), 32'd1);
        chk("ovf_level", 32'(level), 32'd8);
        w_en = 1'b0;
        tick();
        chk("ovf_clear", 32'(w_overflow), 32'd0);
        chk("ovf_data", 32'(r_data), 32'h1);

        // Full with simultaneous read and write: write rejected.
        r_ready = 1'b1; w_en = 1'b1; w_data = 21'hB;
        #1;
        chk("fullrw_wen", 32'(ext_w_en), 32'd0);
        tick();
        chk("fullrw_level", 32'(level), 32'd7);
        chk("fullrw_data", 32'(r_data), 32'h2);
        chk("fullrw_ovf", 32'(w_overflow), 32'd1);
        r_ready = 1'b0;
        #1;
        chk("refill_wen", 32'(ext_w_en), 32'd1);
        chk("refill_waddr", 32'(ext_w_addr), 32'd1);
        tick();
        chk("refill_level", 32'(level), 32'd8);
        chk("refill_ovf", 32'(w_overflow), 32'd0);

        // Drain everything in order.
        w_en = 1'b0; r_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("drain_data", 32'(r_data), exp_drain[j]);
            chk("drain_level", 32'(level), 32'(7 - j));
        end
        tick();
        chk("drain_valid", 32'(r_valid), 32'd0);
        chk("drain_hold", 32'(r_data), 32'hB);

        // Streaming: one in, one out per cycle, level steady at 1.
        for (int i = 0; i < 32; i++) begin
            w_en = 1'b1; w_data = DATA_W'(32'h10 + i);
            tick();
            chk("stream_level", 32'(level), 32'd1);
            if (i == 0) begin
                chk("stream_first_valid", 32'(r_valid), 32'd0);
            end else begin
                chk("stream_valid", 32'(r_valid), 32'd1);
                chk("stream_data", 32'(r_data), 32'(32'h10 + i - 1));
            end
        end
        w_en = 1'b0;
        tick();
        chk("stream_last", 32'(r_data), 32'h2F);
        chk("stream_last_level", 32'(level), 32'd0);
        tick();
        chk("stream_end_valid", 32'(r_valid), 32'd0);

        // Clock enable low freezes everything.
        r_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            w_en = 1'b1; w_data = DATA_W'(32'h61 + k);
            tick();
        end
        chk("cke_pre_level", 32'(level), 32'd2);
        chk("cke_pre_data", 32'(r_data), 32'h61);
        cke = 1'b0; r_ready = 1'b1; w_data = 21'h64;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("cke_wen", 32'(ext_w_en), 32'd0);
            tick();
            chk("cke_level", 32'(level), 32'd2);
            chk("cke_data", 32'(r_data), 32'h61);
            chk("cke_valid", 32'(r_valid), 32'd1);
        end
        cke = 1'b1; r_ready = 1'b0;

        // Reset mid-stream with level 5 and valid output.
        for (int k = 0; k < 3; k++) begin
            w_en = 1'b1; w_data = DATA_W'(32'h70 + k);
            tick();
        end
        w_en = 1'b0;
        chk("prerst_level", 32'(level), 32'd5);
        chk("prerst_valid", 32'(r_valid), 32'd1);
        rst = 1'b1;
        tick();
        chk("mrst_valid", 32'(r_valid), 32'd0);
        chk("mrst_level", 32'(level), 32'd0);
        chk("mrst_data", 32'(r_data), 32'd0);
        chk("mrst_full", 32'(w_full), 32'd0);
        rst = 1'b0;
        w_en = 1'b1; w_data = 21'h55;
        tick();
        w_en = 1'b0;
        chk("post_n1_valid", 32'(r_valid), 32'd0);
        chk("post_n1_level", 32'(level), 32'd1);
        tick();
        chk("post_n2_valid", 32'(r_valid), 32'd1);
        chk("post_n2_data", 32'(r_data), 32'h55);
        chk("post_n2_level", 32'(level), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/iob_regfile_fifo_ctrl.md
Name: iob_regfile_fifo_ctrl

Overview:
Synchronous FIFO controller that owns the write and read ports of an external two-port register file (combinational read, clocked write). It generates the write enable, write address, write data and read address, and registers the read data into a valid/ready output stage. It sits between a streaming producer and a streaming consumer and turns a 2^ADDR_W-entry regfile into a FIFO with 2^ADDR_W+1 entries of total capacity.

Parameters:
ADDR_W, 3, regfile address width; storage depth is 2^ADDR_W; must be >= 1.
DATA_W, 21, data width.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
cke_i  in  1  clock enable; when 0, all state holds
w_en_i  in  1  producer write request
w_data_i  in  DATA_W  producer data
w_full_o  out  1  storage full; a write is not accepted
w_overflow_o  out  1  one-cycle pulse after a write was dropped because storage was full
r_valid_o  out  1  output register holds data
r_ready_i  in  1  consumer accepts r_data_o
r_data_o  out  DATA_W  output data, registered
level_o  out  ADDR_W+1  entries in regfile storage (0..2^ADDR_W), output register excluded
ext_w_en_o  out  1  regfile write enable
ext_w_addr_o  out  ADDR_W  regfile write address
ext_w_data_o  out  DATA_W  regfile write data (w_data_i passthrough)
ext_r_addr_o  out  ADDR_W  regfile read address
ext_r_data_i  in  DATA_W  regfile read data, combinational from ext_r_addr_o

Behaviour:
- Single clock. Reset is synchronous and active-high on rst_i and takes priority over cke_i.
- Reset values: wptr=0, rptr=0, level=0, r_valid_o=0, r_data_o=0, w_overflow_o=0. Hence w_full_o=0 and level_o=0.
- Write accepted: wr = cke_i & w_en_i & ~w_full_o.
  - ext_w_en_o=wr (combinational). ext_w_addr_o=wptr.
  - wptr increments on wr and wraps from 2^ADDR_W-1 to 0.
- Write while full: the data is dropped, pointers and level are unchanged, and w_overflow_o=1 on the next cycle only.
- Load: ld = cke_i & (level!=0) & (~r_valid_o | r_ready_i).
  - ext_r_addr_o=rptr (combinational).
  - On ld: r_data_o<=ext_r_data_i, r_valid_o<=1, rptr increments with wrap.
- Output drain: if r_valid_o & r_ready_i & ~ld, then r_valid_o<=0. r_data_o holds its last value.
- Level update: wr&~ld gives +1; ld&~wr gives -1; wr&ld leaves level unchanged. level never leaves 0..2^ADDR_W.
- w_full_o = (level==2^ADDR_W), derived from the registered level.
  - While full, a write is rejected even if a load frees a slot in the same cycle.
- Empty storage: ld=0 and the regfile is not read. Same-cycle write and empty storage does not bypass into the output.
- Latency: write in cycle N gives level=1 in N+1, load in N+1, and r_valid_o=1 in N+2.
- Throughput: one write and one read per cycle once primed. The output stage is loaded in the same cycle the consumer accepts.
- Read/write same address in one cycle: the read sees the old data, which is correct because rptr==wptr only occurs when empty or full.
- Assertion of rst_i mid-stream discards all contents. No output glitch beyond the reset values.
- cke_i=0: no wr, no ld, ext_w_en_o=0, and w_overflow_o holds.

Optional Feature:
Macro IOB_REGFILE_FIFO_CTRL_ALMOST_EN.
- Defined: adds parameters ALMOST_FULL_LVL (default 2^ADDR_W-1) and ALMOST_EMPTY_LVL (default 1), and ports almost_full_o (level>=ALMOST_FULL_LVL) and almost_empty_o (level<=ALMOST_EMPTY_LVL). Both are combinational from the registered level and reset to 0 and 1 respectively.
- Undefined: these parameters and ports do not exist and behaviour is otherwise identical.

Decomposition:
- Package iob_regfile_fifo_ctrl_pkg: localparam DEPTH=2**ADDR_W expressed as a function of ADDR_W, the level width ADDR_W+1, and a pointer-increment-with-wrap function.
- One natural sub-module, iob_fifo_out_reg: the valid/ready output register stage (ld/drain logic, r_valid_o, r_data_o).
- Pointer and level logic stay in the top level.

Test Plan:
- Reset then idle -> r_valid_o=0, level_o=0, w_full_o=0, ext_w_en_o=0, r_data_o=0.
- ADDR_W=3, r_ready_i=0, write 9 words 0x1..0x9 -> first 8 go to addresses 0..7 with ext_w_en_o=1; after load, level_o=7 and r_data_o=0x1. The 9th write is accepted (level 7->8, wptr wraps to 0). A 10th write 0xA sees w_full_o=1 -> dropped, w_overflow_o=1 for one cycle.
- Continuous write 0x10..0x2F with r_ready_i=1 -> r_data_o sequence identical and in order. First r_valid_o=1 two cycles after the first write; steady level_o=1 and no gaps.
- Full storage, r_ready_i=1 and w_en_i=1 same cycle -> write rejected, level 8->7; next cycle write accepted, level returns to 8.
- rst_i asserted with level_o=5 and r_valid_o=1 -> next cycle all outputs at reset values; a new write 0x55 appears at r_data_o with r_valid_o=1 in N+2.
- cke_i=0 for 3 cycles while w_en_i=1 and r_ready_i=1 -> no ext_w_en_o, and level_o, r_data_o and r_valid_o are unchanged.
